conv_mac_ctrl: RTL and testbench
================================

CONV_MAC_CTRL -- requirements
Module: conv_mac_ctrl

Interface
REQ-001 SHALL have parameter INW, default 16: MAC operand width.
REQ-002 SHALL have parameter OUTW, default 64: MAC accumulator and result width.
REQ-003 SHALL have parameter NMAX, default 16: maximum input matrix dimension.
REQ-004 SHALL have parameter KMAX, default 5: maximum filter dimension.
REQ-005 SHALL derive localparams XAW = clog2(NMAX*NMAX) and WAW = clog2(KMAX*KMAX), each with a minimum of 1.
REQ-006 SHALL have these ports (name direction width meaning); reset is synchronous and active-high, and the clock is clk:
- clk in 1: clock.
- reset in 1: sync active-high reset.
- start in 1: begin a convolution; accepted only in IDLE.
- n in clog2(NMAX+1): input dimension; latched on start.
- k in clog2(KMAX+1): filter dimension; latched on start.
- bias in OUTW: accumulator init value; latched on start.
- busy out 1: high in every state except IDLE.
- done out 1: 1-cycle pulse when the last result handshake completes.
- x_addr out XAW: row-major input-memory read address.
- w_addr out WAW: row-major filter-memory read address.
- x_data in INW: input-memory data, valid 1 cycle after the address.
- w_data in INW: filter-memory data, valid 1 cycle after the address.
- mac_in0 out INW: MAC operand 0; equals x_data.
- mac_in1 out INW: MAC operand 1; equals w_data.
- mac_init_value out OUTW: equals latched bias.
- mac_init_acc out 1: MAC accumulator load strobe.
- mac_input_valid out 1: MAC operand valid.
- mac_out in OUTW: MAC accumulator output (signed).
- y_data out OUTW: result data.
- y_idx out XAW: row-major output index r*(n-k+1)+c.
- y_valid out 1: result valid.
- y_ready in 1: result consumer ready.

Function
REQ-007 SHALL implement the states IDLE, INIT, ISSUE, DRAIN and OUT.
REQ-008 SHALL, in IDLE, on start with 1<=k<=n, latch n, k and bias, clear r, c, i and j, and go to INIT; start with k=0 or k>n SHALL be ignored.
REQ-009 SHALL, in INIT (1 cycle), assert mac_init_acc and go to ISSUE.
REQ-010 SHALL, in ISSUE, present x_addr=(r+i)*n+(c+j) and w_addr=i*k+j for one cycle per tap, stepping j then i, for k*k cycles, then go to DRAIN.
REQ-011 SHALL assert mac_input_valid exactly in the cycle after each ISSUE cycle, making exactly k*k valid cycles per output.
REQ-012 SHALL never assert mac_init_acc in a cycle where a product is pending in the MAC multiply stage, i.e. within 2 cycles after any mac_input_valid.
REQ-013 SHALL stay in DRAIN for 2 cycles and then go to OUT, so that mac_out is final (bias + sum of all taps).
REQ-014 SHALL, in OUT, hold y_valid high and y_data and y_idx stable until y_valid&&y_ready.
REQ-015 SHALL, on the OUT handshake, advance c, and on c wrap advance r; it SHALL go to INIT, or if this was the last output (r=c=n-k), pulse done and go to IDLE.
REQ-016 SHALL spend k*k+3 cycles per output from INIT entry to first y_valid, with y_ready held high.
REQ-017 SHALL ignore start while busy.
REQ-018 SHALL, for n=k, produce exactly one output with y_idx=0.
REQ-019 SHALL perform all index arithmetic unsigned, with no address wrap for legal n and k.

Reset
REQ-020 SHALL, on reset, go to IDLE and clear busy, done, y_valid, mac_init_acc, mac_input_valid, x_addr, w_addr, y_idx and all counters to 0.
REQ-021 SHALL, on reset mid-operation, abandon the operation the following cycle, with no done pulse and no further y_valid.

Configuration
REQ-022 SHALL, with CONV_RELU_EN defined, output y_data=0 when mac_out is negative and y_data=mac_out otherwise.
REQ-023 SHALL, without CONV_RELU_EN, output y_data=mac_out unmodified.

Verification
REQ-024 SHALL cover: n=3, k=3, X=1..9, W all 1, bias=0, y_ready=1 -> one y_valid, y_data=45, y_idx=0, done 1 cycle after the handshake, y_valid at cycle 12 after INIT entry.
REQ-025 SHALL cover: n=4, k=2, X=0..15, W=[1,0,0,1], bias=10 -> y_data 15,17,19,23,25,27,31,33,35 in y_idx order 0..8.
REQ-026 SHALL cover: n=3, k=2, y_ready low for 5 cycles per output -> y_data and y_idx held stable; no lost or duplicate outputs; exactly 4 outputs.
REQ-027 SHALL cover: start with k=4, n=3, and start pulsed while busy -> ignored, busy unchanged.
REQ-028 SHALL cover: reset asserted during ISSUE of the 2nd output -> IDLE next cycle, no done; a new start completes correctly.
REQ-029 SHALL cover: X all -2, W all 1, n=k=2, bias=0 -> y_data=0 with CONV_RELU_EN, y_data=-8 without.

Source files
------------

// File: rtl/conv_mac_ctrl.sv
// conv_mac_ctrl: sequences a 2-D valid-mode convolution through an external MAC.
// It walks every output position, fetches input and filter words from
// row-major memories, feeds the MAC and hands each result out with a
// valid/ready handshake.
// Optional feature: define CONV_RELU_EN to clamp negative results to zero.
module conv_mac_ctrl #(
    parameter int INW  = 16,
    parameter int OUTW = 64,
    parameter int NMAX = 16,
    parameter int KMAX = 5,
    localparam int XAW = ($clog2(NMAX * NMAX) < 1) ? 1 : $clog2(NMAX * NMAX),
    localparam int WAW = ($clog2(KMAX * KMAX) < 1) ? 1 : $clog2(KMAX * KMAX),
    localparam int NW  = $clog2(NMAX + 1),
    localparam int KW  = $clog2(KMAX + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [NW-1:0]   n,
    input  logic [KW-1:0]   k,
    input  logic [OUTW-1:0] bias,
    output logic            busy,
    output logic            done,
    output logic [XAW-1:0]  x_addr,
    output logic [WAW-1:0]  w_addr,
    input  logic [INW-1:0]  x_data,
    input  logic [INW-1:0]  w_data,
    output logic [INW-1:0]  mac_in0,
    output logic [INW-1:0]  mac_in1,
    output logic [OUTW-1:0] mac_init_value,
    output logic            mac_init_acc,
    output logic            mac_input_valid,
    input  logic [OUTW-1:0] mac_out,
    output logic [OUTW-1:0] y_data,
    output logic [XAW-1:0]  y_idx,
    output logic            y_valid,
    input  logic            y_ready
);

    localparam int CW = (NW > KW) ? NW : KW;

    typedef enum logic [2:0] {IDLE, INIT, ISSUE, DRAIN, OUT} state_t;

    state_t          state_q, state_d;
    logic [NW-1:0]   n_q, n_d;
    logic [KW-1:0]   k_q, k_d;
    logic [OUTW-1:0] bias_q, bias_d;
    logic [NW-1:0]   r_q, r_d, c_q, c_d;
    logic [KW-1:0]   i_q, i_d, j_q, j_d;
    logic            drain_q, drain_d;
    logic            valid_q, valid_d;
    logic            done_q, done_d;

    logic [NW-1:0]   last_rc;
    logic            start_ok;
    logic            last_tap;
    logic            last_out;

    assign last_rc  = n_q - NW'(k_q);
    assign start_ok = start && (k != '0) && (CW'(k) <= CW'(n));
    assign last_tap = (i_q == k_q - KW'(1)) && (j_q == k_q - KW'(1));
    assign last_out = (r_q == last_rc) && (c_q == last_rc);

    // State and datapath registers, all cleared by the synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            n_q     <= '0;
            k_q     <= '0;
            bias_q  <= '0;
            r_q     <= '0;
            c_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            drain_q <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            k_q     <= k_d;
            bias_q  <= bias_d;
            r_q     <= r_d;
            c_q     <= c_d;
            i_q     <= i_d;
            j_q     <= j_d;
            drain_q <= drain_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // Next-state selection: INIT -> ISSUE (k*k taps) -> DRAIN (2) -> OUT
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = INIT;
            INIT:    state_d = ISSUE;
            ISSUE:   if (last_tap) state_d = DRAIN;
            DRAIN:   if (drain_q) state_d = OUT;
            OUT:     if (y_ready) state_d = last_out ? IDLE : INIT;
            default: state_d = IDLE;
        endcase
    end

    // Counter, latch and strobe updates; the MAC valid trails ISSUE by one cycle
    always_comb begin
        n_d     = n_q;
        k_d     = k_q;
        bias_d  = bias_q;
        r_d     = r_q;
        c_d     = c_q;
        i_d     = i_q;
        j_d     = j_q;
        drain_d = drain_q;
        valid_d = (state_q == ISSUE);
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    n_d    = n;
                    k_d    = k;
                    bias_d = bias;
                    r_d    = '0;
                    c_d    = '0;
                    i_d    = '0;
                    j_d    = '0;
                end
            end
            ISSUE: begin
                if (j_q == k_q - KW'(1)) begin
                    j_d = '0;
                    i_d = (i_q == k_q - KW'(1)) ? '0 : i_q + KW'(1);
                end else begin
                    j_d = j_q + KW'(1);
                end
            end
            DRAIN: drain_d = ~drain_q;
            OUT: begin
                if (y_ready) begin
                    if (last_out) begin
                        done_d = 1'b1;
                    end else if (c_q == last_rc) begin
                        c_d = '0;
                        r_d = r_q + NW'(1);
                    end else begin
                        c_d = c_q + NW'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    // Output decode from state and counters
    always_comb begin
        busy            = (state_q != IDLE);
        done            = done_q;
        mac_init_acc    = (state_q == INIT);
        mac_input_valid = valid_q;
        y_valid         = (state_q == OUT);
        mac_in0         = x_data;
        mac_in1         = w_data;
        mac_init_value  = bias_q;
        x_addr          = (XAW'(r_q) + XAW'(i_q)) * XAW'(n_q) + XAW'(c_q) + XAW'(j_q);
        w_addr          = WAW'(i_q) * WAW'(k_q) + WAW'(j_q);
        y_idx           = XAW'(r_q) * XAW'(last_rc + NW'(1)) + XAW'(c_q);
`ifdef CONV_RELU_EN
        y_data          = mac_out[OUTW-1] ? '0 : mac_out;
`else
        y_data          = mac_out;
`endif
    end

endmodule

// File: tb/tb_conv_mac_ctrl.sv
// Directed testbench for conv_mac_ctrl with a behavioural two-stage MAC and
// registered-read input/filter memories.
module tb_conv_mac_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  n;
    logic [2:0]  k;
    logic [63:0] bias;
    logic        busy, done;
    logic [7:0]  x_addr;
    logic [4:0]  w_addr;
    logic [15:0] x_data, w_data;
    logic [15:0] mac_in0, mac_in1;
    logic [63:0] mac_init_value;
    logic        mac_init_acc, mac_input_valid;
    logic [63:0] mac_out;
    logic [63:0] y_data;
    logic [7:0]  y_idx;
    logic        y_valid, y_ready;

    int checks = 0;
    int failures = 0;

    logic [15:0] xmem [0:255];
    logic [15:0] wmem [0:31];

    logic signed [63:0] acc;
    logic signed [63:0] prod;
    logic               prod_v;
    logic signed [63:0] op_a, op_b;

    int          got_cnt, first_valid, hs_cyc, done_cyc, hold_err;
    bit          timed_out;
    logic [63:0] got_data [0:15];
    logic [7:0]  got_idx [0:15];

    conv_mac_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .n(n), .k(k), .bias(bias),
        .busy(busy), .done(done), .x_addr(x_addr), .w_addr(w_addr),
        .x_data(x_data), .w_data(w_data), .mac_in0(mac_in0), .mac_in1(mac_in1),
        .mac_init_value(mac_init_value), .mac_init_acc(mac_init_acc),
        .mac_input_valid(mac_input_valid), .mac_out(mac_out),
        .y_data(y_data), .y_idx(y_idx), .y_valid(y_valid), .y_ready(y_ready)
    );

    always #5 clk = ~clk;

    // Memories with one-cycle read latency
    always @(posedge clk) begin
        x_data <= xmem[x_addr];
        w_data <= wmem[w_addr];
    end

    assign op_a = {{48{mac_in0[15]}}, mac_in0};
    assign op_b = {{48{mac_in1[15]}}, mac_in1};
    assign mac_out = acc;

    // MAC: product register followed by accumulate stage
    always @(posedge clk) begin
        prod_v <= mac_input_valid;
        prod   <= op_a * op_b;
        if (mac_init_acc) acc <= $signed(mac_init_value);
        else if (prod_v) acc <= acc + prod;
    end

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic do_start(input int nn, input int kk, input logic [63:0] b);
        @(negedge clk);
        start = 1'b1;
        n = 5'(nn);
        k = 3'(kk);
        bias = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Gathers handshaken results until done; cycle 0 is the call's negedge
    task automatic collect(input int stall, input int budget);
        int waited;
        logic [63:0] hd;
        logic [7:0] hi;
        got_cnt = 0; first_valid = -1; hs_cyc = -1; done_cyc = -1;
        hold_err = 0; timed_out = 1'b1; waited = 0; hd = '0; hi = '0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            if (done) begin
                done_cyc = cyc;
                timed_out = 1'b0;
                break;
            end
            if (y_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (waited == 0) begin
                    hd = y_data;
                    hi = y_idx;
                end else if (y_data !== hd || y_idx !== hi) begin
                    hold_err++;
                end
                if (waited < stall) begin
                    y_ready = 1'b0;
                    waited++;
                end else begin
                    y_ready = 1'b1;
                    if (got_cnt < 16) begin
                        got_data[got_cnt] = y_data;
                        got_idx[got_cnt] = y_idx;
                    end
                    got_cnt++;
                    hs_cyc = cyc;
                    waited = 0;
                end
            end else begin
                y_ready = (stall == 0);
            end
            @(negedge clk);
        end
        y_ready = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got %0b exp 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got %0b exp 0", done); end
        checks++; if (y_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_y_valid got %0b exp 0", y_valid); end
        checks++; if (mac_init_acc !== 1'b0 || mac_input_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_mac_strobes got %0b%0b exp 00", mac_init_acc, mac_input_valid); end
        checks++; if (x_addr !== 8'd0 || w_addr !== 5'd0 || y_idx !== 8'd0) begin failures++; $display("[TB] FAIL reset_addr got x=%0d w=%0d y=%0d exp 0", x_addr, w_addr, y_idx); end
    endtask

    task automatic test_basic();
        for (int i = 0; i < 9; i++) xmem[i] = 16'(i + 1);
        for (int i = 0; i < 9; i++) wmem[i] = 16'd1;
        do_start(3, 3, 64'd0);
        collect(0, 200);
        checks++; if (timed_out) begin failures++; $display("[TB] FAIL basic_timeout got timeout exp done"); end
        checks++; if (got_cnt !== 1) begin failures++; $display("[TB] FAIL basic_count got %0d exp 1", got_cnt); end
        checks++; if (got_data[0] !== 64'd45) begin failures++; $display("[TB] FAIL basic_data got %0d exp 45", got_data[0]); end
        checks++; if (got_idx[0] !== 8'd0) begin failures++; $display("[TB] FAIL basic_idx got %0d exp 0", got_idx[0]); end
        checks++; if (first_valid !== 12) begin failures++; $display("[TB] FAIL basic_latency got %0d exp 12", first_valid); end
        checks++; if (done_cyc !== hs_cyc + 1) begin failures++; $display("[TB] FAIL basic_done_cycle got %0d exp %0d", done_cyc, hs_cyc + 1); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL basic_busy_at_done got %0b exp 0", busy); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL basic_done_pulse got %0b exp 0", done); end
    endtask

    task automatic test_matrix();
        logic [63:0] exp_y [0:8];
        exp_y = '{64'd15, 64'd17, 64'd19, 64'd23, 64'd25, 64'd27, 64'd31, 64'd33, 64'd35};
        for (int i = 0; i < 16; i++) xmem[i] = 16'(i);
        wmem[0] = 16'd1; wmem[1] = 16'd0; wmem[2] = 16'd0; wmem[3] = 16'd1;
        do_start(4, 2, 64'd10);
        checks++; if (mac_init_acc !== 1'b1 || mac_init_value !== 64'd10) begin failures++; $display("[TB] FAIL matrix_init got acc=%0b val=%0d exp 1 10", mac_init_acc, mac_init_value); end
        @(negedge clk);
        checks++; if (x_addr !== 8'd0 || w_addr !== 5'd0) begin failures++; $display("[TB] FAIL matrix_tap0 got x=%0d w=%0d exp 0 0", x_addr, w_addr); end
        @(negedge clk);
        checks++; if (x_addr !== 8'd1 || w_addr !== 5'd1 || mac_input_valid !== 1'b1) begin failures++; $display("[TB] FAIL matrix_tap1 got x=%0d w=%0d v=%0b exp 1 1 1", x_addr, w_addr, mac_input_valid); end
        @(negedge clk);
        checks++; if (x_addr !== 8'd4 || w_addr !== 5'd2) begin failures++; $display("[TB] FAIL matrix_tap2 got x=%0d w=%0d exp 4 2", x_addr, w_addr); end
        collect(0, 400);
        checks++; if (timed_out || got_cnt !== 9) begin failures++; $display("[TB] FAIL matrix_count got %0d exp 9", got_cnt); end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (got_data[i] !== exp_y[i] || got_idx[i] !== 8'(i)) begin
                failures++;
                $display("[TB] FAIL matrix_out%0d got data=%0d idx=%0d exp data=%0d idx=%0d", i, got_data[i], got_idx[i], exp_y[i], i);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] exp_y [0:3];
        exp_y = '{64'd37, 64'd47, 64'd67, 64'd77};
        for (int i = 0; i < 9; i++) xmem[i] = 16'(i + 1);
        wmem[0] = 16'd1; wmem[1] = 16'd2; wmem[2] = 16'd3; wmem[3] = 16'd4;
        do_start(3, 2, 64'd0);
        collect(5, 400);
        checks++; if (timed_out || got_cnt !== 4) begin failures++; $display("[TB] FAIL bp_count got %0d exp 4", got_cnt); end
        checks++; if (hold_err !== 0) begin failures++; $display("[TB] FAIL bp_hold got %0d unstable cycles exp 0", hold_err); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_data[i] !== exp_y[i] || got_idx[i] !== 8'(i)) begin
                failures++;
                $display("[TB] FAIL bp_out%0d got data=%0d idx=%0d exp data=%0d idx=%0d", i, got_data[i], got_idx[i], exp_y[i], i);
            end
        end
    endtask

    task automatic test_illegal_start();
        do_start(3, 4, 64'd0);
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL illegal_k_gt_n got busy=%0b exp 0", busy); end
        do_start(3, 0, 64'd0);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL illegal_k0 got busy=%0b exp 0", busy); end
        for (int i = 0; i < 9; i++) xmem[i] = 16'(i + 1);
        for (int i = 0; i < 9; i++) wmem[i] = 16'd1;
        do_start(3, 3, 64'd0);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; n = 5'd4; k = 3'd2; bias = 64'd100;
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL busy_start got busy=%0b exp 1", busy); end
        collect(0, 200);
        checks++; if (timed_out || got_cnt !== 1 || got_data[0] !== 64'd45) begin failures++; $display("[TB] FAIL busy_start_result got cnt=%0d data=%0d exp 1 45", got_cnt, got_data[0]); end
    endtask

    task automatic test_reset_midop();
        int seen_done;
        logic [63:0] exp_y [0:3];
        exp_y = '{64'd37, 64'd47, 64'd67, 64'd77};
        for (int i = 0; i < 9; i++) xmem[i] = 16'(i + 1);
        wmem[0] = 16'd1; wmem[1] = 16'd2; wmem[2] = 16'd3; wmem[3] = 16'd4;
        y_ready = 1'b1;
        do_start(3, 2, 64'd0);
        // cycle 7 first handshake, 8 INIT, 9..12 ISSUE of the second output
        for (int i = 0; i < 10; i++) @(negedge clk);
        checks++; if (busy !== 1'b1 || y_valid !== 1'b0 || mac_init_acc !== 1'b0) begin failures++; $display("[TB] FAIL midop_in_issue got busy=%0b yv=%0b init=%0b exp 1 0 0", busy, y_valid, mac_init_acc); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || y_valid !== 1'b0 || mac_input_valid !== 1'b0) begin failures++; $display("[TB] FAIL midop_abandon got busy=%0b done=%0b yv=%0b mv=%0b exp 0000", busy, done, y_valid, mac_input_valid); end
        seen_done = 0;
        for (int i = 0; i < 20; i++) begin
            if (done || y_valid) seen_done++;
            @(negedge clk);
        end
        checks++; if (seen_done !== 0) begin failures++; $display("[TB] FAIL midop_quiet got %0d active cycles exp 0", seen_done); end
        do_start(3, 2, 64'd0);
        collect(0, 400);
        checks++; if (timed_out || got_cnt !== 4) begin failures++; $display("[TB] FAIL midop_restart_count got %0d exp 4", got_cnt); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_data[i] !== exp_y[i] || got_idx[i] !== 8'(i)) begin
                failures++;
                $display("[TB] FAIL midop_out%0d got data=%0d idx=%0d exp data=%0d idx=%0d", i, got_data[i], got_idx[i], exp_y[i], i);
            end
        end
    endtask

    task automatic test_relu();
        logic [63:0] exp_v;
`ifdef CONV_RELU_EN
        exp_v = 64'd0;
`else
        exp_v = -64'sd8;
`endif
        for (int i = 0; i < 4; i++) xmem[i] = 16'hFFFE;
        for (int i = 0; i < 4; i++) wmem[i] = 16'd1;
        do_start(2, 2, 64'd0);
        collect(0, 200);
        checks++; if (timed_out || got_cnt !== 1) begin failures++; $display("[TB] FAIL relu_count got %0d exp 1", got_cnt); end
        checks++; if (got_data[0] !== exp_v || got_idx[0] !== 8'd0) begin failures++; $display("[TB] FAIL relu_data got data=%0d idx=%0d exp data=%0d idx=0", $signed(got_data[0]), got_idx[0], $signed(exp_v)); end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; n = '0; k = '0; bias = '0; y_ready = 1'b1;
        acc = '0; prod = '0; prod_v = 1'b0;
        for (int i = 0; i < 256; i++) xmem[i] = '0;
        for (int i = 0; i < 32; i++) wmem[i] = '0;
        test_reset();
        test_basic();
        test_matrix();
        test_backpressure();
        test_illegal_start();
        test_reset_midop();
        test_relu();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
